// File: rtl/multicycle_control_pkg.sv
// Shared MIPS control encodings: FSM states, opcodes and datapath select codes.
// Imported by the multicycle sequencer, the datapath and the single-cycle decoder.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_LWWB    = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_RWB     = 4'd8,
    S_EXEC_I  = 4'd9,
    S_IWB     = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_LUI   = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 4'b1000;

  localparam logic [SEL_W-1:0] RD_RT = 2'b00;
  localparam logic [SEL_W-1:0] RD_RD = 2'b01;
  localparam logic [SEL_W-1:0] RD_RA = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RT    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

  // Full control word produced by the sequencer each cycle.
  typedef struct packed {
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic [SEL_W-1:0]   reg_dest;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [SEL_W-1:0]   pc_source;
    logic               is_jal;
    logic               is_signed;
    logic               instr_done;
    logic               illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               mem_ready;

  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               PCWrite;
  logic               MemtoReg;
  logic               RegWrite;
  logic [SEL_W-1:0]   RegDest;
  logic               ALUSrcA;
  logic [SEL_W-1:0]   ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [SEL_W-1:0]   PcSource;
  logic               isJAL;
  logic               isSigned;
  logic               instr_done;
  logic               illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, PCWrite, MemtoReg, RegWrite,
           RegDest, ALUSrcA, ALUSrcB, ALUOp, PcSource, isJAL, isSigned,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, PCWrite, MemtoReg, RegWrite,
           RegDest, ALUSrcA, ALUSrcB, ALUOp, PcSource, isJAL, isSigned,
           instr_done, illegal_op
  );

endinterface

// File: rtl/multicycle_control_iop_decode.sv
// I-type ALU opcode decode: ALU operation, immediate sign-extension and membership flag.
module mips_iop_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_signed,
  output logic               is_itype
);

  always_comb begin
    alu_op    = ALU_ADD;
    is_signed = 1'b0;
    is_itype  = 1'b1;
    case (opcode)
      OP_ADDI:  begin alu_op = ALU_ADD;  is_signed = 1'b1; end
      OP_ANDI:  alu_op = ALU_AND;
      OP_ORI:   alu_op = ALU_OR;
      OP_XORI:  alu_op = ALU_XOR;
      OP_SLTI:  begin alu_op = ALU_SLT;  is_signed = 1'b1; end
      // sltiu compares unsigned but still sign-extends its immediate
      OP_SLTIU: begin alu_op = ALU_SLTU; is_signed = 1'b1; end
      OP_LUI:   alu_op = ALU_LUI;
      default:  is_itype = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: steps each instruction through fetch/decode/execute/memory/writeback.
// Outputs decode from the state (plus opcode, mem_ready and zero where needed), so reset clears them at once.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_control_if.master bus
);

  state_t               state;
  state_t               state_nxt;
  ctrl_t                c;
  logic [ALUOP_W-1:0]   iop_alu_op;
  logic                 iop_signed;
  logic                 iop_valid;

  mips_iop_decode u_iop (
    .opcode    (bus.opcode),
    .alu_op    (iop_alu_op),
    .is_signed (iop_signed),
    .is_itype  (iop_valid)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and control-word decode
  always_comb begin
    state_nxt = state;
    c         = '0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_ALU;
        c.ir_write  = bus.mem_ready;
        c.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_DECODE;
      end

      // Branch target is precomputed here into ALUOut
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        c.alu_op    = ALU_ADD;
        c.is_signed = 1'b1;
        case (bus.opcode)
          OP_LW, OP_SW:   state_nxt = S_MEMADDR;
          OP_RTYPE:       state_nxt = S_EXEC_R;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J, OP_JAL:   state_nxt = S_JUMP;
          default: begin
            if (iop_valid) begin
              state_nxt = S_EXEC_I;
            end else begin
              c.illegal_op = 1'b1;
              state_nxt    = S_FETCH;
            end
          end
        endcase
      end

      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        c.is_signed = 1'b1;
        state_nxt   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        if (bus.mem_ready) state_nxt = S_LWWB;
      end

      S_LWWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dest   = RD_RT;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end

      // Store completes on the accepting edge, so done pulses only then
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end

      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
        state_nxt   = S_RWB;
      end

      S_RWB: begin
        c.reg_write  = 1'b1;
        c.reg_dest   = RD_RD;
        c.alu_op     = ALU_FUNCT;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = iop_alu_op;
        c.is_signed = iop_signed;
        state_nxt   = S_IWB;
      end

      S_IWB: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_IMM;
        c.alu_op     = iop_alu_op;
        c.is_signed  = iop_signed;
        c.reg_write  = 1'b1;
        c.reg_dest   = RD_RT;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_RT;
        c.alu_op     = ALU_SUB;
        c.pc_source  = PC_ALUOUT;
        c.pc_write   = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end

      // jal links the current PC, which already holds PC+4 from fetch
      S_JUMP: begin
        c.pc_source  = PC_JUMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
        if (bus.opcode == OP_JAL) begin
          c.reg_write = 1'b1;
          c.reg_dest  = RD_RA;
          c.is_jal    = 1'b1;
        end
        state_nxt = S_FETCH;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.IorD       = c.iord;
  assign bus.MemRead    = c.mem_read;
  assign bus.MemWrite   = c.mem_write;
  assign bus.IRWrite    = c.ir_write;
  assign bus.PCWrite    = c.pc_write;
  assign bus.MemtoReg   = c.mem_to_reg;
  assign bus.RegWrite   = c.reg_write;
  assign bus.RegDest    = c.reg_dest;
  assign bus.ALUSrcA    = c.alu_src_a;
  assign bus.ALUSrcB    = c.alu_src_b;
  assign bus.ALUOp      = c.alu_op;
  assign bus.PcSource   = c.pc_source;
  assign bus.isJAL      = c.is_jal;
  assign bus.isSigned   = c.is_signed;
  assign bus.instr_done = c.instr_done;
  assign bus.illegal_op = c.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words queued, then checked.
module tb_multicycle_control;

  logic clk;
  logic reset_n;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [21:0] exp_q[$];
  logic        rdy_q[$];

  // {IorD,MemRead,MemWrite,IRWrite,PCWrite,MemtoReg,RegWrite,RegDest,ALUSrcA,ALUSrcB,ALUOp,PcSource,isJAL,isSigned,instr_done,illegal_op}
  function automatic logic [21:0] pk(input logic iord, mr, mw, irw, pcw, m2r, rw,
                                     input logic [1:0] rd, input logic sa, input logic [1:0] sb,
                                     input logic [3:0] aop, input logic [1:0] ps,
                                     input logic jal, sgn, done, ill);
    return {iord, mr, mw, irw, pcw, m2r, rw, rd, sa, sb, aop, ps, jal, sgn, done, ill};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.MemtoReg,
            bus.RegWrite, bus.RegDest, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PcSource,
            bus.isJAL, bus.isSigned, bus.instr_done, bus.illegal_op};
  endfunction

  function automatic logic [21:0] e_fetch(input logic r);
    return pk(0,1,0,r,r,0,0,2'b00,0,2'b01,4'b0000,2'b00,0,0,0,0);
  endfunction
  function automatic logic [21:0] e_decode(input logic ill);
    return pk(0,0,0,0,0,0,0,2'b00,0,2'b11,4'b0000,2'b00,0,1,0,ill);
  endfunction
  function automatic logic [21:0] e_memaddr();
    return pk(0,0,0,0,0,0,0,2'b00,1,2'b10,4'b0000,2'b00,0,1,0,0);
  endfunction
  function automatic logic [21:0] e_memrd();
    return pk(1,1,0,0,0,0,0,2'b00,0,2'b00,4'b0000,2'b00,0,0,0,0);
  endfunction
  function automatic logic [21:0] e_lwwb();
    return pk(0,0,0,0,0,1,1,2'b00,0,2'b00,4'b0000,2'b00,0,0,1,0);
  endfunction
  function automatic logic [21:0] e_memwr(input logic r);
    return pk(1,0,1,0,0,0,0,2'b00,0,2'b00,4'b0000,2'b00,0,0,r,0);
  endfunction
  function automatic logic [21:0] e_execr();
    return pk(0,0,0,0,0,0,0,2'b00,1,2'b00,4'b0010,2'b00,0,0,0,0);
  endfunction
  function automatic logic [21:0] e_rwb();
    return pk(0,0,0,0,0,0,1,2'b01,0,2'b00,4'b0010,2'b00,0,0,1,0);
  endfunction
  function automatic logic [21:0] e_execi(input logic [3:0] a, input logic s);
    return pk(0,0,0,0,0,0,0,2'b00,1,2'b10,a,2'b00,0,s,0,0);
  endfunction
  function automatic logic [21:0] e_iwb(input logic [3:0] a, input logic s);
    return pk(0,0,0,0,0,0,1,2'b00,1,2'b10,a,2'b00,0,s,1,0);
  endfunction
  function automatic logic [21:0] e_branch(input logic p);
    return pk(0,0,0,0,p,0,0,2'b00,1,2'b00,4'b0001,2'b01,0,0,1,0);
  endfunction
  function automatic logic [21:0] e_jump(input logic j);
    return pk(0,0,0,0,1,0,j,(j ? 2'b10 : 2'b00),0,2'b00,4'b0000,2'b10,j,0,1,0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic [21:0] e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  // Play queued cycles: drive mem_ready, compare at negedge, then check latency to instr_done.
  task automatic drain(input logic [5:0] op, input logic z, input string tag, input int exp_lat);
    int n   = 0;
    int lat = 0;
    logic [21:0] e;
    bus.opcode = op;
    bus.zero   = z;
    while (exp_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      n++;
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, n), 32'(obs()), 32'(e));
      if (bus.instr_done && lat == 0) lat = n;
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset held three cycles with mem_ready high: everything quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_c%0d", i), 32'(obs()), 32'd0);
      @(posedge clk);
    end
    #1;
    reset_n = 1'b1;

    // IDLE cycle, then a zero-wait addi
    push(22'd0, 1);
    drain(6'b001000, 0, "idle", 0);
    push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execi(4'b0000, 1), 1); push(e_iwb(4'b0000, 1), 1);
    drain(6'b001000, 0, "addi", 4);

    // lw with two wait cycles in MEMRD
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_memaddr(), 1);
    push(e_memrd(), 0); push(e_memrd(), 0); push(e_memrd(), 1); push(e_lwwb(), 1);
    drain(6'b100011, 0, "lw", 7);

    // beq taken, bne not taken with zero=1
    push(e_fetch(1), 1); push(e_decode(0), 0); push(e_branch(1), 1);
    drain(6'b000100, 1, "beq", 3);
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_branch(0), 1);
    drain(6'b000101, 1, "bne", 3);
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_branch(1), 0);
    drain(6'b000101, 0, "bne_nz", 3);

    // Jumps
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_jump(1), 1);
    drain(6'b000011, 0, "jal", 3);
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_jump(0), 1);
    drain(6'b000010, 0, "j", 3);

    // R-type with one fetch wait state
    push(e_fetch(0), 0); push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execr(), 1); push(e_rwb(), 1);
    drain(6'b000000, 0, "rtype", 5);

    // Remaining I-type flavours
    push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execi(4'b0101, 0), 1); push(e_iwb(4'b0101, 0), 1);
    drain(6'b001101, 0, "ori", 4);
    push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execi(4'b1000, 1), 1); push(e_iwb(4'b1000, 1), 1);
    drain(6'b001011, 0, "sltiu", 4);
    push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execi(4'b0111, 0), 1); push(e_iwb(4'b0111, 0), 1);
    drain(6'b001111, 0, "lui", 4);
    push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execi(4'b0110, 0), 1); push(e_iwb(4'b0110, 0), 1);
    drain(6'b001110, 0, "xori", 4);

    // sw with one wait in MEMWR
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_memaddr(), 1);
    push(e_memwr(0), 0); push(e_memwr(1), 1);
    drain(6'b101011, 0, "sw", 5);

    // Illegal opcode: pulse in DECODE, then back in FETCH (held there by mem_ready=0)
    push(e_fetch(1), 1); push(e_decode(1), 1); push(e_fetch(0), 0);
    drain(6'b111111, 0, "illegal", 0);

    // sw stalled in MEMWR, then reset asserted between edges
    push(e_fetch(1), 1); push(e_decode(0), 1); push(e_memaddr(), 1);
    push(e_memwr(0), 0); push(e_memwr(0), 0);
    drain(6'b101011, 0, "sw_stall", 0);
    chk("sw_pre_reset_memwrite", 32'(bus.MemWrite), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_async_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("reset_async_all", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Recovery: IDLE then a clean andi
    push(22'd0, 1); push(e_fetch(1), 1); push(e_decode(0), 1);
    push(e_execi(4'b0100, 0), 1); push(e_iwb(4'b0100, 0), 1);
    drain(6'b001100, 0, "andi_after_reset", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
